// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-side line reader and a data-side line reader/writer
// onto a single burst-oriented backing-memory port. A line is LINE_W bits and
// moves as BURST_LEN beats of BEAT_W bits, beat 0 (line LSBs) first.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   i_read_i, i_addr_i             instruction line read request (held until i_resp_o)
//   i_rdata_o, i_resp_o            instruction line data, one-cycle completion pulse
//   d_read_i, d_write_i            data line read / write request (held until d_resp_o)
//   d_addr_i, d_wdata_i            data line address and write line
//   d_rdata_o, d_resp_o            data line data, one-cycle completion pulse
//   bmem_read_o, bmem_write_o      burst command, held for the whole burst
//   bmem_addr_o, bmem_wdata_o      line-aligned burst address, current write beat
//   bmem_rdata_i, bmem_resp_i      read beat, one beat accepted/returned per cycle high
//   busy_o                         high whenever a transaction is in flight
//
// Build option
//   ARB_RR_EN  defined: round-robin between simultaneous I and D requests.
//              undefined: fixed priority, the data side wins.
module mem_arbiter #(
  parameter  int BEAT_W    = 64,
  parameter  int BURST_LEN = 4,
  localparam int LINE_W    = BEAT_W * BURST_LEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_read_i,
  input  logic [31:0]       i_addr_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [31:0]       d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_resp_o,
  output logic              bmem_read_o,
  output logic              bmem_write_o,
  output logic [31:0]       bmem_addr_o,
  output logic [BEAT_W-1:0] bmem_wdata_o,
  input  logic [BEAT_W-1:0] bmem_rdata_i,
  input  logic              bmem_resp_i,
  output logic              busy_o
);

  localparam int               OFF_W     = $clog2(LINE_W / 8);
  localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE_I, DONE_D} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  // One buffer serves both directions: it holds the write line during a
  // write burst and collects returned beats during a read burst.
  logic [LINE_W-1:0] line_q, line_d;

  logic i_req, d_req, grant_d;

  assign i_req = i_read_i;
  assign d_req = d_read_i | d_write_i;

`ifdef ARB_RR_EN
  // Remembers which side won the most recent grant; reset value means
  // "instruction last", so the first contested grant goes to data.
  logic last_d_q, last_d_d;

  assign grant_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      last_d_d = grant_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  // State register (FSM state plus the datapath it sequences)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          addr_d = d_addr_i & ADDR_MASK;
          // A simultaneous read+write is serviced as a write.
          if (d_write_i) begin
            state_d = D_WR;
            line_d  = d_wdata_i;
          end else begin
            state_d = D_RD;
          end
        end else if (i_req) begin
          addr_d  = i_addr_i & ADDR_MASK;
          state_d = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (bmem_resp_i) begin
          if (state_q != D_WR) begin
            line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = bmem_rdata_i;
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = (state_q == I_RD) ? DONE_I : DONE_D;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bmem_read_o  = 1'b0;
    bmem_write_o = 1'b0;
    i_resp_o     = 1'b0;
    d_resp_o     = 1'b0;
    unique case (state_q)
      I_RD, D_RD: bmem_read_o  = 1'b1;
      D_WR:       bmem_write_o = 1'b1;
      DONE_I:     i_resp_o     = 1'b1;
      DONE_D:     d_resp_o     = 1'b1;
      default:    ;
    endcase
  end

  // Beat-sliced view of the line buffer for the write-beat mux.
  logic [BEAT_W-1:0] beat_view [BURST_LEN];

  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_beat
    assign beat_view[gi] = line_q[gi * BEAT_W +: BEAT_W];
  end

  assign bmem_wdata_o = bmem_write_o ? beat_view[cnt_q] : '0;
  assign bmem_addr_o  = addr_q;
  assign busy_o       = (state_q != IDLE);
  assign i_rdata_o    = line_q;
  assign d_rdata_o    = line_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BEAT_W, 64, data width of one burst beat on the backing-memory port.
REQ-002 Parameter BURST_LEN, 4, beats per line; line width LINE_W = BEAT_W*BURST_LEN (256 by default).
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 i_read_i  in  1  instruction-side line read request, held until i_resp_o.
REQ-006 i_addr_i  in  32  instruction line address.
REQ-007 i_rdata_o  out  LINE_W  instruction line data, valid while i_resp_o.
REQ-008 i_resp_o  out  1  one-cycle instruction completion pulse.
REQ-009 d_read_i / d_write_i  in  1 each  data-side line read/write request, held until d_resp_o.
REQ-010 d_addr_i  in  32  data line address; d_wdata_i  in  LINE_W  write line.
REQ-011 d_rdata_o  out  LINE_W  data line, valid while d_resp_o; d_resp_o  out  1  one-cycle completion pulse.
REQ-012 bmem_read_o / bmem_write_o  out  1 each  backing-memory burst command, held for the whole burst.
REQ-013 bmem_addr_o  out  32  line-aligned burst address; bmem_wdata_o  out  BEAT_W  current write beat.
REQ-014 bmem_rdata_i  in  BEAT_W  read beat; bmem_resp_i  in  1  one beat accepted/returned per asserted cycle.
REQ-015 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, I_RD, D_RD, D_WR, DONE_I, DONE_D.
REQ-017 IDLE: with a pending request, the grant is registered, address latched with low log2(LINE_W/8) bits forced to zero, d_wdata_i latched for writes; next state I_RD/D_RD/D_WR.
REQ-018 Simultaneous d_read_i and d_write_i SHALL be serviced as a write.
REQ-019 Burst states: bmem_read_o or bmem_write_o SHALL be high every cycle, bmem_addr_o stable; beat counter increments on each bmem_resp_i.
REQ-020 Write beat k SHALL be latched line bits [k*BEAT_W +: BEAT_W], beat 0 first; read beat k SHALL be stored into the same slice of a shared line buffer.
REQ-021 On bmem_resp_i with counter = BURST_LEN-1, counter SHALL clear and state go to DONE_I (I_RD) or DONE_D (D_RD/D_WR); bmem command deasserts that edge.
REQ-022 DONE_x: corresponding resp_o high exactly one cycle, rdata_o = line buffer; next state IDLE unconditionally.
REQ-023 Requester deassertion mid-burst SHALL be ignored; burst completes and resp still pulses.
REQ-024 Latency: request sampled in IDLE at cycle 0, zero-wait memory -> bmem command cycles 1..BURST_LEN, resp_o at cycle BURST_LEN+1 (5 default).
REQ-025 Back-to-back: a request first seen in the IDLE cycle after DONE SHALL be granted there; minimum issue interval BURST_LEN+2 cycles.
REQ-026 i_resp_o and d_resp_o SHALL never be high together; bmem_read_o and bmem_write_o SHALL never be high together.
REQ-027 Instruction side SHALL never cause bmem_write_o.

Reset
REQ-028 On rst_ni low, asynchronously: state IDLE, counter 0, all outputs 0, line buffer 0, round-robin pointer selects instruction as last-granted.
REQ-029 Reset mid-burst SHALL abort the burst immediately with no resp pulse; after release, requests still held SHALL be re-arbitrated from IDLE.

Configuration
REQ-030 Macro ARB_RR_EN defined: on simultaneous I and D requests in IDLE, grant the side not granted last; pointer updates on each grant.
REQ-031 ARB_RR_EN undefined: fixed priority, data side always wins simultaneous requests; pointer logic absent.
REQ-032 A single pending requester SHALL be granted in IDLE in both configurations.

Verification
REQ-033 i_read_i=1, i_addr_i=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. with zero wait -> bmem_addr_o=0x0000_1220, i_resp_o at cycle 5, i_rdata_o = {0x44..,0x33..,0x22..,0x11..}.
REQ-034 d_write_i=1, d_wdata_i low beat 0xA5A5_A5A5_A5A5_A5A5, bmem_resp_i with 2-cycle gaps -> bmem_wdata_o beat 0 = 0xA5A5_A5A5_A5A5_A5A5 held until first resp, d_resp_o once after 4th resp.
REQ-035 i_read_i and d_read_i asserted together three times -> ARB_RR_EN: grants D,I,D; without: D every time, I only after D drops.
REQ-036 rst_ni low after beat 2 of a D_RD -> bmem_read_o=0 immediately, no d_resp_o; held d_read_i re-granted and completes with 4 fresh beats.
REQ-037 d_read_i and d_write_i both 1 -> bmem_write_o burst, bmem_read_o never high, single d_resp_o.
